// File: rtl/mem_rw_arbiter_if.sv
// mem_rw_arbiter_if: client request/response and RAM-side signals of mem_rw_arbiter
// Ports carried (grouped, no clock/reset):
//   read clients : rd_req_valid/ready/addr, rd_resp_valid/ready/data
//   write clients: wr_valid/ready/addr/data/strb
//   memory       : ren/raddr/rdata, wen/waddr/wdata/wstrb
// slave is the arbiter side; master is the clients plus memory side.
interface mem_rw_arbiter_if #(
  parameter int N_RD       = 2,
  parameter int N_WR       = 2,
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 128
);
  logic [N_RD-1:0]              rd_req_valid;
  logic [N_RD-1:0]              rd_req_ready;
  logic [N_RD*ADDR_WIDTH-1:0]   rd_req_addr;
  logic [N_RD-1:0]              rd_resp_valid;
  logic [N_RD-1:0]              rd_resp_ready;
  logic [DATA_WIDTH-1:0]        rd_resp_data;
  logic [N_WR-1:0]              wr_valid;
  logic [N_WR-1:0]              wr_ready;
  logic [N_WR*ADDR_WIDTH-1:0]   wr_addr;
  logic [N_WR*DATA_WIDTH-1:0]   wr_data;
  logic [N_WR*DATA_WIDTH/8-1:0] wr_strb;
  logic                         ren;
  logic [ADDR_WIDTH-1:0]        raddr;
  logic [DATA_WIDTH-1:0]        rdata;
  logic                         wen;
  logic [ADDR_WIDTH-1:0]        waddr;
  logic [DATA_WIDTH-1:0]        wdata;
  logic [DATA_WIDTH/8-1:0]      wstrb;
  modport slave (
    input  rd_req_valid, rd_req_addr, rd_resp_ready, wr_valid, wr_addr, wr_data, wr_strb, rdata,
    output rd_req_ready, rd_resp_valid, rd_resp_data, wr_ready, ren, raddr, wen, waddr, wdata, wstrb
  );
  modport master (
    output rd_req_valid, rd_req_addr, rd_resp_ready, wr_valid, wr_addr, wr_data, wr_strb, rdata,
    input  rd_req_ready, rd_resp_valid, rd_resp_data, wr_ready, ren, raddr, wen, waddr, wdata, wstrb
  );
endinterface

// File: rtl/mem_rw_arbiter.sv
// mem_rw_arbiter: multiplexes N_RD read and N_WR write clients onto one word-addressed RAM port
// Ports: clk, rstn (async active-low), bus (mem_rw_arbiter_if.slave: client handshakes and RAM signals).
// Reads: credit-gated arbitration, registered ren/raddr, tag pipeline aligned with rdata,
// in-order response FIFO. Writes: arbitration, registered wen/waddr/wdata/wstrb.
// MEM_ARB_FIXED_PRIO_EN: when defined both arbiters are fixed priority (lowest index wins),
// otherwise round-robin starting after the last granted client.
module mem_rw_arbiter #(
  parameter int N_RD       = 2,
  parameter int N_WR       = 2,
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 128,
  parameter int RD_LATENCY = 1,
  parameter int RESP_DEPTH = 4
) (
  input logic             clk,
  input logic             rstn,
  mem_rw_arbiter_if.slave bus
);
  localparam int RW = N_RD > 1 ? $clog2(N_RD) : 1;
  localparam int WW = N_WR > 1 ? $clog2(N_WR) : 1;
  localparam int PW = RESP_DEPTH > 1 ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 1);
  logic                  wg_v, rg_v, wr_acc, rd_acc, raw, push, pop;
  logic [WW-1:0]         wg_i;
  logic [RW-1:0]         rg_i;
  logic [CW-1:0]         credits, cnt;
  logic [PW-1:0]         rp, wp;
  logic [RW-1:0]         ren_tag;
  logic [RD_LATENCY-1:0] tp_v;
  logic [RW-1:0]         tp_i [RD_LATENCY];
  logic [DATA_WIDTH-1:0] fifo_d [RESP_DEPTH];
  logic [RW-1:0]         fifo_t [RESP_DEPTH];
`ifdef MEM_ARB_FIXED_PRIO_EN
  always_comb begin
    wg_v = 1'b0;
    wg_i = '0;
    rg_v = 1'b0;
    rg_i = '0;
    for (int k = N_WR - 1; k >= 0; k--)
      if (bus.wr_valid[k]) begin
        wg_v = 1'b1;
        wg_i = WW'(k);
      end
    for (int k = N_RD - 1; k >= 0; k--)
      if (bus.rd_req_valid[k]) begin
        rg_v = 1'b1;
        rg_i = RW'(k);
      end
  end
`else
  logic [WW-1:0] wr_ptr;
  logic [RW-1:0] rd_ptr;
  // Descending scan so the candidate closest to the pointer is the last (winning) assignment.
  always_comb begin
    wg_v = 1'b0;
    wg_i = '0;
    rg_v = 1'b0;
    rg_i = '0;
    for (int k = N_WR - 1; k >= 0; k--)
      if (bus.wr_valid[(int'(wr_ptr) + k) % N_WR]) begin
        wg_v = 1'b1;
        wg_i = WW'((int'(wr_ptr) + k) % N_WR);
      end
    for (int k = N_RD - 1; k >= 0; k--)
      if (bus.rd_req_valid[(int'(rd_ptr) + k) % N_RD]) begin
        rg_v = 1'b1;
        rg_i = RW'((int'(rd_ptr) + k) % N_RD);
      end
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= WW'((int'(wg_i) + 1) % N_WR);
      if (rd_acc) rd_ptr <= RW'((int'(rg_i) + 1) % N_RD);
    end
`endif
  // A read to the address being written this cycle waits one cycle so memory sees the write first.
  assign raw = wg_v && bus.wr_addr[wg_i*ADDR_WIDTH +: ADDR_WIDTH] == bus.rd_req_addr[rg_i*ADDR_WIDTH +: ADDR_WIDTH];
  assign wr_acc = rstn && wg_v;
  assign rd_acc = rstn && rg_v && credits != '0 && !raw;
  assign bus.wr_ready = wr_acc ? N_WR'(1) << wg_i : '0;
  assign bus.rd_req_ready = rd_acc ? N_RD'(1) << rg_i : '0;
  assign push = tp_v[RD_LATENCY-1];
  assign bus.rd_resp_valid = cnt != '0 ? N_RD'(1) << fifo_t[rp] : '0;
  assign bus.rd_resp_data = fifo_d[rp];
  assign pop = |(bus.rd_resp_valid & bus.rd_resp_ready);
  // Credits cover both the tag pipeline and the FIFO, so a push always finds room.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      bus.wen   <= 1'b0;
      bus.waddr <= '0;
      bus.wdata <= '0;
      bus.wstrb <= '0;
      bus.ren   <= 1'b0;
      bus.raddr <= '0;
      ren_tag   <= '0;
      tp_v      <= '0;
      for (int k = 0; k < RD_LATENCY; k++) tp_i[k] <= '0;
      rp        <= '0;
      wp        <= '0;
      cnt       <= '0;
      credits   <= CW'(RESP_DEPTH);
    end else begin
      bus.wen <= wr_acc;
      if (wr_acc) begin
        bus.waddr <= bus.wr_addr[wg_i*ADDR_WIDTH +: ADDR_WIDTH];
        bus.wdata <= bus.wr_data[wg_i*DATA_WIDTH +: DATA_WIDTH];
        bus.wstrb <= bus.wr_strb[wg_i*(DATA_WIDTH/8) +: DATA_WIDTH/8];
      end
      bus.ren <= rd_acc;
      if (rd_acc) begin
        bus.raddr <= bus.rd_req_addr[rg_i*ADDR_WIDTH +: ADDR_WIDTH];
        ren_tag   <= rg_i;
      end
      tp_v[0] <= bus.ren;
      tp_i[0] <= ren_tag;
      for (int k = 1; k < RD_LATENCY; k++) begin
        tp_v[k] <= tp_v[k-1];
        tp_i[k] <= tp_i[k-1];
      end
      if (push) wp <= wp == PW'(RESP_DEPTH - 1) ? '0 : wp + PW'(1);
      if (pop) rp <= rp == PW'(RESP_DEPTH - 1) ? '0 : rp + PW'(1);
      cnt     <= cnt + CW'(push) - CW'(pop);
      credits <= credits - CW'(rd_acc) + CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) begin
      fifo_d[wp] <= bus.rdata;
      fifo_t[wp] <= tp_i[RD_LATENCY-1];
    end
endmodule

// File: tb/tb_mem_rw_arbiter.sv
// tb_mem_rw_arbiter: directed self-checking bench for mem_rw_arbiter with a strobed RAM model
module tb_mem_rw_arbiter;
  localparam int N_RD = 2, N_WR = 2, AW = 28, DW = 128, LAT = 1, DEPTH = 4, SW = DW / 8;
`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  always #5 clk = ~clk;
  mem_rw_arbiter_if #(.N_RD(N_RD), .N_WR(N_WR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  mem_rw_arbiter #(.N_RD(N_RD), .N_WR(N_WR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                   .RD_LATENCY(LAT), .RESP_DEPTH(DEPTH)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  logic [DW-1:0] mem [256];
  logic [DW-1:0] rpipe [LAT];
  assign bus.rdata = rpipe[LAT-1];
  always @(posedge clk) begin
    if (bus.wen)
      for (int b = 0; b < SW; b++)
        if (bus.wstrb[b]) mem[bus.waddr[7:0]][b*8 +: 8] <= bus.wdata[b*8 +: 8];
    rpipe[0] <= mem[bus.raddr[7:0]];
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_write(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    bus.wr_valid[c] = 1'b1;
    bus.wr_addr[c*AW +: AW] = a;
    bus.wr_data[c*DW +: DW] = d;
    bus.wr_strb[c*SW +: SW] = s;
    #1;
    n_cmp++;
    if (bus.wr_ready[c] !== 1'b1) begin n_err++; $display("FAIL wr_grant c%0d: got %b exp 1", c, bus.wr_ready[c]); end
    tick;
    bus.wr_valid[c] = 1'b0;
    tick;
  endtask
  task automatic do_read(input int c, input logic [AW-1:0] a, output logic [DW-1:0] d, output int n);
    bus.rd_req_valid[c] = 1'b1;
    bus.rd_req_addr[c*AW +: AW] = a;
    tick;
    bus.rd_req_valid[c] = 1'b0;
    n = 1;
    while (bus.rd_resp_valid === '0 && n < 12) begin tick; n++; end
    d = bus.rd_resp_data;
    tick;
  endtask
  task automatic test_reset;
    rstn = 1'b0;
    bus.rd_req_valid = '1;
    bus.wr_valid = '1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.ren, bus.wen} !== 2'b00) begin n_err++; $display("FAIL reset_en: got %b exp 00", {bus.ren, bus.wen}); end
    n_cmp++;
    if ({bus.raddr, bus.waddr} !== '0) begin n_err++; $display("FAIL reset_addr: got %h %h exp 0", bus.raddr, bus.waddr); end
    n_cmp++;
    if ({bus.wdata, bus.wstrb} !== '0) begin n_err++; $display("FAIL reset_wdata: got %h %h exp 0", bus.wdata, bus.wstrb); end
    n_cmp++;
    if ({bus.rd_req_ready, bus.wr_ready, bus.rd_resp_valid} !== '0) begin
      n_err++; $display("FAIL reset_handshake: got %b %b %b exp 0", bus.rd_req_ready, bus.wr_ready, bus.rd_resp_valid);
    end
    bus.rd_req_valid = '0;
    bus.wr_valid = '0;
    rstn = 1'b1;
    tick;
  endtask
  task automatic test_write_rr;
    logic [1:0] exp;
    bus.wr_valid = 2'b11;
    bus.wr_addr = {AW'('h61), AW'('h60)};
    bus.wr_data = {DW'('h61), DW'('h60)};
    bus.wr_strb = '1;
    for (int k = 0; k < 4; k++) begin
      exp = FIXED ? 2'b01 : (k % 2 == 1 ? 2'b10 : 2'b01);
      #1;
      n_cmp++;
      if (bus.wr_ready !== exp) begin n_err++; $display("FAIL wr_rr_ready[%0d]: got %b exp %b", k, bus.wr_ready, exp); end
      tick;
      n_cmp++;
      if ({bus.wen, bus.waddr} !== {1'b1, AW'(exp == 2'b10 ? 'h61 : 'h60)}) begin
        n_err++; $display("FAIL wr_rr_mem[%0d]: got wen=%b waddr=%h exp 1 %h", k, bus.wen, bus.waddr, exp == 2'b10 ? 'h61 : 'h60);
      end
    end
    bus.wr_valid = '0;
    tick;
    n_cmp++;
    if (bus.wen !== 1'b0) begin n_err++; $display("FAIL wr_rr_idle: got wen=%b exp 0", bus.wen); end
  endtask
  task automatic test_write_read;
    int n;
    bus.rd_resp_ready = 2'b11;
    bus.wr_valid = 2'b01;
    bus.wr_addr[0 +: AW] = AW'('h10);
    bus.wr_data[0 +: DW] = {SW{8'hA5}};
    bus.wr_strb[0 +: SW] = '1;
    #1;
    n_cmp++;
    if (bus.wr_ready !== 2'b01) begin n_err++; $display("FAIL wr_ready: got %b exp 01", bus.wr_ready); end
    tick;
    bus.wr_valid = '0;
    n_cmp++;
    if ({bus.wen, bus.waddr, bus.wdata} !== {1'b1, AW'('h10), {SW{8'hA5}}}) begin
      n_err++; $display("FAIL wen_beat: got %b %h %h exp 1 10 a5..", bus.wen, bus.waddr, bus.wdata);
    end
    tick;
    n_cmp++;
    if (bus.wen !== 1'b0) begin n_err++; $display("FAIL wen_pulse: got %b exp 0", bus.wen); end
    bus.rd_req_valid = 2'b10;
    bus.rd_req_addr[AW +: AW] = AW'('h10);
    #1;
    n_cmp++;
    if (bus.rd_req_ready !== 2'b10) begin n_err++; $display("FAIL rd_ready: got %b exp 10", bus.rd_req_ready); end
    tick;
    bus.rd_req_valid = '0;
    n_cmp++;
    if ({bus.ren, bus.raddr} !== {1'b1, AW'('h10)}) begin n_err++; $display("FAIL ren_issue: got %b %h exp 1 10", bus.ren, bus.raddr); end
    n = 1;
    while (bus.rd_resp_valid === '0 && n < 12) begin tick; n++; end
    n_cmp++;
    if (n !== LAT + 2) begin n_err++; $display("FAIL rd_latency: got %0d exp %0d", n, LAT + 2); end
    n_cmp++;
    if ({bus.rd_resp_valid, bus.rd_resp_data} !== {2'b10, {SW{8'hA5}}}) begin
      n_err++; $display("FAIL rd_resp: got %b %h exp 10 a5..", bus.rd_resp_valid, bus.rd_resp_data);
    end
    tick;
    n_cmp++;
    if (bus.rd_resp_valid !== 2'b00) begin n_err++; $display("FAIL rd_resp_pop: got %b exp 00", bus.rd_resp_valid); end
  endtask
  task automatic test_rr_fairness;
    int c0, c1;
    logic [1:0] exp;
    c0 = 0;
    c1 = 0;
    bus.rd_req_valid = 2'b11;
    bus.rd_req_addr = {AW'('h41), AW'('h40)};
    for (int k = 0; k < 8; k++) begin
      exp = FIXED ? 2'b01 : (k % 2 == 1 ? 2'b10 : 2'b01);
      #1;
      n_cmp++;
      if (bus.rd_req_ready !== exp) begin n_err++; $display("FAIL rd_rr_ready[%0d]: got %b exp %b", k, bus.rd_req_ready, exp); end
      c0 += int'(bus.rd_req_ready[0]);
      c1 += int'(bus.rd_req_ready[1]);
      tick;
    end
    bus.rd_req_valid = '0;
    n_cmp++;
    if (c0 !== (FIXED ? 8 : 4) || c1 !== (FIXED ? 0 : 4)) begin
      n_err++; $display("FAIL rd_rr_count: got %0d/%0d exp %0d/%0d", c0, c1, FIXED ? 8 : 4, FIXED ? 0 : 4);
    end
    repeat (8) tick;
  endtask
  task automatic test_backpressure;
    int acc;
    bus.rd_resp_ready = 2'b00;
    bus.rd_req_valid = 2'b01;
    bus.rd_req_addr[0 +: AW] = AW'('h50);
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      acc += int'(bus.rd_req_ready[0]);
      tick;
    end
    n_cmp++;
    if (acc !== DEPTH) begin n_err++; $display("FAIL bp_accepts: got %0d exp %0d", acc, DEPTH); end
    n_cmp++;
    if (bus.rd_req_ready !== 2'b00) begin n_err++; $display("FAIL bp_ready_low: got %b exp 00", bus.rd_req_ready); end
    n_cmp++;
    if (bus.rd_resp_valid !== 2'b01) begin n_err++; $display("FAIL bp_head: got %b exp 01", bus.rd_resp_valid); end
    bus.rd_resp_ready = 2'b01;
    tick;
    bus.rd_resp_ready = 2'b00;
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      acc += int'(bus.rd_req_ready[0]);
      tick;
    end
    n_cmp++;
    if (acc !== 1) begin n_err++; $display("FAIL bp_after_pop: got %0d exp 1", acc); end
    bus.rd_req_valid = '0;
    bus.rd_resp_ready = 2'b11;
    repeat (10) tick;
  endtask
  task automatic test_raw;
    int n;
    do_write(0, AW'('h20), DW'('h5555), '1);
    bus.wr_valid = 2'b01;
    bus.wr_addr[0 +: AW] = AW'('h20);
    bus.wr_data[0 +: DW] = DW'('h1234);
    bus.wr_strb[0 +: SW] = '1;
    bus.rd_req_valid = 2'b01;
    bus.rd_req_addr[0 +: AW] = AW'('h20);
    #1;
    n_cmp++;
    if ({bus.wr_ready, bus.rd_req_ready} !== 4'b0100) begin
      n_err++; $display("FAIL raw_block: got wr=%b rd=%b exp 01 00", bus.wr_ready, bus.rd_req_ready);
    end
    tick;
    bus.wr_valid = '0;
    n_cmp++;
    if ({bus.wen, bus.ren} !== 2'b10) begin n_err++; $display("FAIL raw_order: got wen=%b ren=%b exp 1 0", bus.wen, bus.ren); end
    #1;
    n_cmp++;
    if (bus.rd_req_ready !== 2'b01) begin n_err++; $display("FAIL raw_retry: got %b exp 01", bus.rd_req_ready); end
    tick;
    bus.rd_req_valid = '0;
    n = 1;
    while (bus.rd_resp_valid === '0 && n < 12) begin tick; n++; end
    n_cmp++;
    if ({bus.rd_resp_valid, bus.rd_resp_data} !== {2'b01, DW'('h1234)}) begin
      n_err++; $display("FAIL raw_data: got %b %h exp 01 1234", bus.rd_resp_valid, bus.rd_resp_data);
    end
    tick;
  endtask
  task automatic test_strobes;
    logic [DW-1:0] d;
    int n;
    do_write(0, AW'('h30), '1, '1);
    do_write(1, AW'('h30), '0, SW'('h0001));
    n_cmp++;
    if ({bus.wstrb, bus.wdata} !== {SW'('h0001), DW'(0)}) begin
      n_err++; $display("FAIL strb_out: got %h %h exp 0001 0", bus.wstrb, bus.wdata);
    end
    do_read(0, AW'('h30), d, n);
    n_cmp++;
    if (d !== 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF00) begin n_err++; $display("FAIL strb_data: got %h exp ff..ff00", d); end
    n_cmp++;
    if (n !== LAT + 2) begin n_err++; $display("FAIL strb_latency: got %0d exp %0d", n, LAT + 2); end
  endtask
  task automatic test_reset_mid_read;
    int acc, stale;
    bus.rd_resp_ready = 2'b11;
    bus.rd_req_valid = 2'b11;
    bus.rd_req_addr = {AW'('h30), AW'('h10)};
    tick;
    tick;
    #2;
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({bus.ren, bus.raddr, bus.rd_req_ready, bus.rd_resp_valid} !== '0) begin
      n_err++; $display("FAIL midrst_out: got ren=%b raddr=%h rdy=%b rv=%b exp 0", bus.ren, bus.raddr, bus.rd_req_ready, bus.rd_resp_valid);
    end
    bus.rd_req_valid = '0;
    tick;
    tick;
    rstn = 1'b1;
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      tick;
      if (bus.rd_resp_valid !== 2'b00) stale++;
    end
    n_cmp++;
    if (stale !== 0) begin n_err++; $display("FAIL midrst_stale: got %0d cycles with rd_resp_valid exp 0", stale); end
    bus.rd_resp_ready = 2'b00;
    bus.rd_req_valid = 2'b01;
    bus.rd_req_addr[0 +: AW] = AW'('h50);
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      acc += int'(bus.rd_req_ready[0]);
      tick;
    end
    n_cmp++;
    if (acc !== DEPTH) begin n_err++; $display("FAIL midrst_credits: got %0d exp %0d", acc, DEPTH); end
    bus.rd_req_valid = '0;
    bus.rd_resp_ready = 2'b11;
    repeat (8) tick;
  endtask
  initial begin
    bus.rd_req_valid = '0;
    bus.rd_req_addr = '0;
    bus.rd_resp_ready = 2'b11;
    bus.wr_valid = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.wr_strb = '0;
    test_reset;
    test_write_rr;
    test_write_read;
    test_rr_fairness;
    test_backpressure;
    test_raw;
    test_strobes;
    test_reset_mid_read;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end
endmodule

// File: doc/mem_rw_arbiter.md
Name: mem_rw_arbiter

Overview:
- Multiplexes N_RD read clients and N_WR write clients onto one word-addressed RAM interface: ren/raddr/rdata and wen/waddr/wdata/wstrb.
- It is the parametrised successor of the single-client RAM port used by the top-level AXI benches. It adds multiple channels, configurable read latency, response backpressure and read-after-write ordering.
- Sits between DMA/engine clients and the DPI-backed or on-chip memory.

Parameters:
N_RD, 2, number of read clients (1..8)
N_WR, 2, number of write clients (1..8)
ADDR_WIDTH, 28, word address width (AXI_ADDR_WIDTH-LSB)
DATA_WIDTH, 128, memory word width; multiple of 8
RD_LATENCY, 1, cycles from ren asserted to rdata valid (1..8)
RESP_DEPTH, 4, response FIFO depth; must be >= RD_LATENCY+1

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
rd_req_valid  in  N_RD  per-client read request valid
rd_req_ready  out  N_RD  per-client read request accept
rd_req_addr  in  N_RD*ADDR_WIDTH  packed read addresses, client i at [i*ADDR_WIDTH +: ADDR_WIDTH]
rd_resp_valid  out  N_RD  per-client read data valid
rd_resp_ready  in  N_RD  per-client read data accept
rd_resp_data  out  DATA_WIDTH  read data, shared bus, qualified by rd_resp_valid
wr_valid  in  N_WR  per-client write valid
wr_ready  out  N_WR  per-client write accept
wr_addr  in  N_WR*ADDR_WIDTH  packed write addresses
wr_data  in  N_WR*DATA_WIDTH  packed write data
wr_strb  in  N_WR*DATA_WIDTH/8  packed byte strobes
ren  out  1  memory read enable
raddr  out  ADDR_WIDTH  memory read address
rdata  in  DATA_WIDTH  memory read data, valid RD_LATENCY cycles after ren
wen  out  1  memory write enable
waddr  out  ADDR_WIDTH  memory write address
wdata  out  DATA_WIDTH  memory write data
wstrb  out  DATA_WIDTH/8  memory byte strobes

Behaviour:
- Reset (rstn low, async): ren, wen, all *_ready and rd_resp_valid = 0; raddr, waddr, wdata, wstrb = 0; RR pointers = 0; FIFO empty; credits = RESP_DEPTH; tag pipeline cleared. Reset mid-transaction discards in-flight reads; rdata arriving after reset is ignored.
- Write path:
  - Round-robin over wr_valid, starting at the index after the last grant. At most one write per cycle.
  - wr_ready[i] is combinational and high only for the granted client. wr_ready never depends on wr_ready.
  - The accepted beat is registered onto wen/waddr/wdata/wstrb the next cycle (1-cycle latency). wen is a one-cycle pulse per beat.
- Read path:
  - Round-robin over rd_req_valid, gated by credits > 0.
  - The accepted request drives ren/raddr the next cycle (registered) and pushes the client index into a RD_LATENCY-deep tag shift register aligned with rdata.
  - credits decrements on accept and increments on FIFO pop; simultaneous accept and pop leave it unchanged.
  - When credits == 0, all rd_req_ready = 0.
- Response FIFO:
  - Each returned rdata plus its tag is pushed; overflow is impossible by the credit rule.
  - The head drives rd_resp_data, and rd_resp_valid[tag] = 1 with all other bits 0.
  - Pop on rd_resp_valid[tag] & rd_resp_ready[tag]. Strictly in-order: a stalled head blocks all read responses (head-of-line blocking by design).
- RAW ordering: if a read request is arbitrated in the same cycle as a write grant with an equal address, the read is not accepted that cycle (its rd_req_ready = 0). It wins the next cycle, so the read reaches memory after the write.
- Read and write may be accepted in the same cycle for different addresses; ren and wen may be high together.
- RR pointers advance only on a handshake. An idle cycle keeps the pointer.
- A single requester is granted every cycle (throughput 1/cycle per direction).

Optional Feature:
MEM_ARB_FIXED_PRIO_EN:
- Defined: both arbiters use fixed priority, lowest index wins, and the pointers are removed.
- Undefined (default): round-robin as above.
- Handshake, latency and RAW rules are identical in both modes.

Test Plan:
- Single write then read: wr client 0 writes addr 0x10, data 0xA5..A5, strb all 1; rd client 1 reads 0x10 -> wen pulses 1 cycle after accept; rd_resp_valid=2'b10 with 0xA5..A5 at RD_LATENCY+2 cycles after read accept.
- RR fairness: both read clients hold valid for 8 cycles -> grants alternate 0,1,0,1…, 4 each. With MEM_ARB_FIXED_PRIO_EN -> client 0 gets all 8.
- Backpressure: RESP_DEPTH=4, rd_resp_ready=0, client 0 streams reads -> exactly 4 accepted, then rd_req_ready=0. After one pop, exactly one more is accepted.
- RAW same cycle: write addr 0x20 = 0x1234 and read addr 0x20 presented together -> read delayed one cycle and returns 0x1234, not the old value.
- Strobes: write 0xFFFF..FF then write 0x00..00 with strb=16'h0001 to 0x30 -> read returns 0xFF..FF00.
- Reset mid-read: assert rstn=0 while 2 reads are in flight -> outputs 0 immediately, credits=4 after release, no stale rd_resp_valid.
